// File: rtl/rtl_constants.sv
// Shared sizing, FSM states and per-entry metadata for the BRATCR checkpoint controller.
package rtl_constants;

    localparam int ISSUE_WIDTH_MAX     = 2;
    localparam int BRATCR_NUM_ETY      = 4;
    localparam int BRATCR_NUM_ETY_CLOG = $clog2(BRATCR_NUM_ETY);
    localparam int ROB_SIZE_CLOG       = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESTORE  = 2'd1,
        WAIT_ACK = 2'd2
    } bratcr_state_e;

    typedef struct packed {
        logic                     valid;
        logic [ROB_SIZE_CLOG-1:0] robid;
    } bratcr_meta_t;

    // Distance from the ROB head; wraps naturally in ROB_SIZE_CLOG bits.
    function automatic logic [ROB_SIZE_CLOG-1:0] rob_age(
        input logic [ROB_SIZE_CLOG-1:0] robid,
        input logic [ROB_SIZE_CLOG-1:0] head
    );
        return robid - head;
    endfunction

endpackage

// File: rtl/bratcr_free_pick.sv
// Priority encoder: lowest ISSUE_WIDTH_MAX free checkpoint ids (slot order) plus free-entry count.
module bratcr_free_pick
    import rtl_constants::*;
(
    input  logic [BRATCR_NUM_ETY-1:0]                      free_vec,
    output logic [ISSUE_WIDTH_MAX*BRATCR_NUM_ETY_CLOG-1:0] pick_id,
    output logic [BRATCR_NUM_ETY_CLOG:0]                   free_cnt
);

    localparam int NE = BRATCR_NUM_ETY;
    localparam int CW = BRATCR_NUM_ETY_CLOG;
    localparam int IW = ISSUE_WIDTH_MAX;

    logic [NE-1:0] avail;
    logic          found;

    always_comb begin
        avail    = free_vec;
        pick_id  = '0;
        free_cnt = '0;
        found    = 1'b0;
        for (int i = 0; i < NE; i++) begin
            free_cnt = free_cnt + {{CW{1'b0}}, free_vec[i]};
        end
        // Each pick consumes its id so the next pick finds the next-lowest one.
        for (int s = 0; s < IW; s++) begin
            found = 1'b0;
            for (int i = 0; i < NE; i++) begin
                if (!found && avail[i]) begin
                    found               = 1'b1;
                    pick_id[s*CW +: CW] = CW'(i);
                    avail[i]            = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/bratcr_ctrl.sv
// Checkpoint allocation, free-on-resolve and mispredict recovery sequencing for the FRAT copies.
module bratcr_ctrl
    import rtl_constants::*;
(
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [ISSUE_WIDTH_MAX-1:0]                     ckpt_req_id,
    input  logic [ISSUE_WIDTH_MAX*ROB_SIZE_CLOG-1:0]       robid_id,
    input  logic [ROB_SIZE_CLOG-1:0]                       rob_head_ptr,
    input  logic                                           resolve_val,
    input  logic [BRATCR_NUM_ETY_CLOG-1:0]                 resolve_ckpt_id,
    input  logic                                           resolve_mispred,
    input  logic                                           rob_flush_ack,
    input  logic                                           full_flush,
    output logic [ISSUE_WIDTH_MAX-1:0]                     ckpt_gnt_id,
    output logic [ISSUE_WIDTH_MAX*BRATCR_NUM_ETY_CLOG-1:0] ckpt_id_id,
    output logic                                           rename_stall,
    output logic                                           restore_val,
    output logic [BRATCR_NUM_ETY_CLOG-1:0]                 restore_ckpt_id,
    output logic [BRATCR_NUM_ETY-1:0]                      ckpt_valid
);

    localparam int NE = BRATCR_NUM_ETY;
    localparam int CW = BRATCR_NUM_ETY_CLOG;
    localparam int IW = ISSUE_WIDTH_MAX;
    localparam int RW = ROB_SIZE_CLOG;

    bratcr_state_e state_reg, state_next;
    logic [CW-1:0] lat_id_reg, lat_id_next;
    logic [RW-1:0] lat_age_reg, lat_age_next;

    logic [NE-1:0]    valid_vec;
    logic [NE*RW-1:0] age_flat;
    logic [NE-1:0]    free_vec;
    logic [IW*CW-1:0] pick_id;
    logic [CW:0]      free_cnt;
    logic [CW:0]      req_cnt;
    logic             alloc_ok;
    logic             res_valid;
    logic [RW-1:0]    res_age;
    logic             mispred_hit;
    logic             free_hit;
    int               rank;

    assign free_vec   = ~valid_vec;
    assign ckpt_valid = valid_vec;

    bratcr_free_pick u_free_pick (
        .free_vec (free_vec),
        .pick_id  (pick_id),
        .free_cnt (free_cnt)
    );

    assign res_valid   = valid_vec[resolve_ckpt_id];
    assign res_age     = age_flat[resolve_ckpt_id*RW +: RW];
    assign mispred_hit = resolve_val & resolve_mispred & res_valid;
    assign free_hit    = resolve_val & ~resolve_mispred & res_valid;

    // All-or-nothing allocation; a mispredict or flush in the same cycle wins over rename.
    always_comb begin
        req_cnt = '0;
        for (int s = 0; s < IW; s++) begin
            req_cnt = req_cnt + {{CW{1'b0}}, ckpt_req_id[s]};
        end
        alloc_ok = rst && (state_reg == IDLE) && !full_flush && !mispred_hit
                   && (free_cnt >= req_cnt);
        ckpt_gnt_id = '0;
        ckpt_id_id  = '0;
        rank        = 0;
        for (int s = 0; s < IW; s++) begin
            if (ckpt_req_id[s]) begin
                if (alloc_ok) begin
                    ckpt_gnt_id[s]         = 1'b1;
                    ckpt_id_id[s*CW +: CW] = pick_id[rank*CW +: CW];
                end
                rank = rank + 1;
            end
        end
    end

    assign rename_stall    = rst && ((state_reg != IDLE) || ((|ckpt_req_id) && !alloc_ok));
    assign restore_val     = (state_reg == RESTORE);
    assign restore_ckpt_id = lat_id_reg;

    always_comb begin
        state_next   = state_reg;
        lat_id_next  = lat_id_reg;
        lat_age_next = lat_age_reg;
        case (state_reg)
            IDLE: begin
                if (mispred_hit) begin
                    lat_id_next  = resolve_ckpt_id;
                    lat_age_next = res_age;
                    state_next   = RESTORE;
                end
            end
            RESTORE: state_next = WAIT_ACK;
            WAIT_ACK: begin
                // Only an older live branch can supersede the recovery already under way.
                if (mispred_hit && (res_age < lat_age_reg)) begin
                    lat_id_next  = resolve_ckpt_id;
                    lat_age_next = res_age;
                    state_next   = RESTORE;
                end else if (rob_flush_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (full_flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            lat_id_reg  <= '0;
            lat_age_reg <= '0;
        end else begin
            state_reg   <= state_next;
            lat_id_reg  <= lat_id_next;
            lat_age_reg <= lat_age_next;
        end
    end

    for (genvar gi = 0; gi < NE; gi++) begin : g_ety
        bratcr_meta_t  meta_reg;
        logic          alloc_hit;
        logic [RW-1:0] alloc_robid;
        logic          kill;
        logic          freed;

        always_comb begin
            alloc_hit   = 1'b0;
            alloc_robid = '0;
            for (int s = 0; s < IW; s++) begin
                if (ckpt_gnt_id[s] && (ckpt_id_id[s*CW +: CW] == CW'(gi))) begin
                    alloc_hit   = 1'b1;
                    alloc_robid = robid_id[s*RW +: RW];
                end
            end
        end

        assign kill  = (state_reg == RESTORE) &&
                       ((lat_id_reg == CW'(gi)) || (age_flat[gi*RW +: RW] > lat_age_reg));
        assign freed = free_hit && (resolve_ckpt_id == CW'(gi));

        always_ff @(posedge clk) begin
            if (!rst) begin
                meta_reg <= '0;
            end else if (full_flush) begin
                meta_reg.valid <= 1'b0;
            end else if (alloc_hit) begin
                meta_reg.valid <= 1'b1;
                meta_reg.robid <= alloc_robid;
            end else if (kill || freed) begin
                meta_reg.valid <= 1'b0;
            end
        end

        assign valid_vec[gi]          = meta_reg.valid;
        assign age_flat[gi*RW +: RW]  = rob_age(meta_reg.robid, rob_head_ptr);
    end

endmodule

// File: tb/tb_bratcr_ctrl.sv
// Scoreboard bench for bratcr_ctrl: each cycle's expected outputs are queued at drive time and checked at negedge.
module tb_bratcr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ckpt_req_id;
    logic [9:0] robid_id;
    logic [4:0] rob_head_ptr;
    logic       resolve_val;
    logic [1:0] resolve_ckpt_id;
    logic       resolve_mispred;
    logic       rob_flush_ack;
    logic       full_flush;
    logic [1:0] ckpt_gnt_id;
    logic [3:0] ckpt_id_id;
    logic       rename_stall;
    logic       restore_val;
    logic [1:0] restore_ckpt_id;
    logic [3:0] ckpt_valid;

    always #5 clk = ~clk;

    bratcr_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .ckpt_req_id     (ckpt_req_id),
        .robid_id        (robid_id),
        .rob_head_ptr    (rob_head_ptr),
        .resolve_val     (resolve_val),
        .resolve_ckpt_id (resolve_ckpt_id),
        .resolve_mispred (resolve_mispred),
        .rob_flush_ack   (rob_flush_ack),
        .full_flush      (full_flush),
        .ckpt_gnt_id     (ckpt_gnt_id),
        .ckpt_id_id      (ckpt_id_id),
        .rename_stall    (rename_stall),
        .restore_val     (restore_val),
        .restore_ckpt_id (restore_ckpt_id),
        .ckpt_valid      (ckpt_valid)
    );

    typedef struct {
        logic [1:0] gnt;
        logic [3:0] ids;
        logic       stall;
        logic       rval;
        logic [1:0] rid;
        logic [3:0] valid;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;
    logic [4:0] head = 5'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL txn %0d %s: got %0h expected %0h", txn, tag, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("gnt",   32'(ckpt_gnt_id),  32'(e.gnt));
                check("ids",   32'(ckpt_id_id),   32'(e.ids));
                check("stall", 32'(rename_stall), 32'(e.stall));
                check("rval",  32'(restore_val),  32'(e.rval));
                if (e.rval) check("rid", 32'(restore_ckpt_id), 32'(e.rid));
                check("valid", 32'(ckpt_valid),   32'(e.valid));
                $display("txn %0d: gnt=%b ids=%b stall=%b rval=%b rid=%0d valid=%b",
                         txn, ckpt_gnt_id, ckpt_id_id, rename_stall, restore_val,
                         restore_ckpt_id, ckpt_valid);
                txn++;
            end
        end
    end

    task automatic drive(input logic [1:0] req, input logic [4:0] r1, input logic [4:0] r0,
                         input logic rv, input logic rm, input logic [1:0] rid,
                         input logic ack, input logic ff);
        ckpt_req_id     = req;
        robid_id        = {r1, r0};
        rob_head_ptr    = head;
        resolve_val     = rv;
        resolve_mispred = rm;
        resolve_ckpt_id = rid;
        rob_flush_ack   = ack;
        full_flush      = ff;
    endtask

    // One cycle: drive inputs, queue what the outputs must be before the next edge.
    task automatic cyc(input logic [1:0] req, input logic [4:0] r1, input logic [4:0] r0,
                       input logic rv, input logic rm, input logic [1:0] rid,
                       input logic ack, input logic ff,
                       input logic [1:0] e_gnt, input logic [3:0] e_ids, input logic e_stall,
                       input logic e_rval, input logic [1:0] e_rid, input logic [3:0] e_valid);
        exp_t e;
        drive(req, r1, r0, rv, rm, rid, ack, ff);
        e.gnt = e_gnt; e.ids = e_ids; e.stall = e_stall;
        e.rval = e_rval; e.rid = e_rid; e.valid = e_valid;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : timeout
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        exp_t e;
        rst = 1'b0;
        drive(2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        e.gnt = 2'b00; e.ids = 4'b0000; e.stall = 1'b0;
        e.rval = 1'b0; e.rid = 2'd0; e.valid = 4'b0000;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // req  r1     r0     rv    rm    rid   ack   ff   | gnt    ids       stall rval  rid   valid
        // basic dual grant, then fill to 4
        cyc(2'b11, 5'd5,  5'd4,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b11, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000);
        cyc(2'b11, 5'd7,  5'd6,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b11, 4'b1110, 1'b0, 1'b0, 2'd0, 4'b0011);
        // freed id not grantable the same cycle, granted next cycle
        cyc(2'b01, 5'd0,  5'd9,  1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b1111);
        cyc(2'b01, 5'd0,  5'd9,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b01, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b1011);
        cyc(2'b00, 5'd0,  5'd0,  1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b1111);
        // two requests, one free: all-or-nothing stall
        cyc(2'b11, 5'd11, 5'd10, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0111);
        cyc(2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0111);
        // robids 3,6,9; mispredict on robid 6 (id1) beats a same-cycle request
        cyc(2'b11, 5'd6,  5'd3,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b11, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000);
        cyc(2'b01, 5'd0,  5'd9,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b01, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0011);
        cyc(2'b01, 5'd0,  5'd11, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0111);
        cyc(2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0111);
        cyc(2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001);
        cyc(2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001);
        cyc(2'b01, 5'd0,  5'd10, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b01, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0001);
        // re-latch in WAIT_ACK: squashed id ignored, older id1 (robid 10) restarts recovery
        cyc(2'b01, 5'd0,  5'd12, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b01, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0011);
        cyc(2'b00, 5'd0,  5'd0,  1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0111);
        cyc(2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0111);
        cyc(2'b00, 5'd0,  5'd0,  1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0011);
        cyc(2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0011);
        cyc(2'b00, 5'd0,  5'd0,  1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0011);
        cyc(2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0011);
        cyc(2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001);
        cyc(2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0001);
        // wrap-around ages with head 30: robids 30,31,1; mispredict on 31 squashes robid 1
        head = 5'd30;
        cyc(2'b11, 5'd31, 5'd30, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b11, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000);
        cyc(2'b01, 5'd0,  5'd1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b01, 4'b0010, 1'b0, 1'b0, 2'd0, 4'b0011);
        cyc(2'b00, 5'd0,  5'd0,  1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0111);
        cyc(2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0111);
        cyc(2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001);
        // full_flush during RESTORE with a simultaneous request
        cyc(2'b00, 5'd0,  5'd0,  1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0001);
        cyc(2'b11, 5'd3,  5'd2,  1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001);
        cyc(2'b01, 5'd0,  5'd2,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);
        cyc(2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0001);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
